// File: rtl/mem_arb2.sv
// Round-robin two-master arbiter for the single shared fixed-latency memory port.
// One access in flight at a time; the winner gets a one-cycle ack with read data.
module mem_arb2 #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        win;
  logic        any_req;

  // On a tie the port that was not served last wins.
  assign any_req = m0_req | m1_req;
  assign win     = (m0_req & m1_req) ? ~last_q : m1_req;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d  = win;
          last_d   = win;
          cnt_d    = '0;
          we_d     = win ? m1_we : m0_we;
          addr_d   = win ? m1_addr : m0_addr;
          wdata_d  = win ? m1_wdata : m0_wdata;
          mem_en_d = 1'b1;
          mem_we_d = win ? m1_we : m0_we;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LAT_M1) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_ack    = (state_q == DONE) & ~owner_q;
  assign m1_ack    = (state_q == DONE) & owner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign state     = state_q;

endmodule
